// File: rtl/spi_rx_byte_fifo.sv
// SPI mode-0 slave receiver: synchronises SCK/MOSI/CSb into clk, assembles MSB-first bytes
// and buffers them (with a first-of-transaction tag) in a first-word-fall-through FIFO.
module spi_rx_byte_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_csb,
  output logic [7:0] m_data,
  output logic       m_first,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       overflow,
  output logic       abort,
  output logic       active
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] fill_sync;

  logic       sck_s;
  logic       mosi_s;
  logic       csb_s;
  logic       csb_s_vld;
  logic       sck_prev;
  logic       csb_prev;
  logic       csb_prev_vld;
  logic       sck_rise;
  logic       csb_fall;

  logic [0:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       first_pend;
  logic       push;
  logic [8:0] push_data;

  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic [8:0]  head;

  // fill_sync marks which synchroniser samples came from the pins rather than the reset fill,
  // so the forced-high CSb after reset cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      csb_sync  <= '1;
      fill_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0],  spi_csb};
      fill_sync <= {fill_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign csb_s_vld = fill_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_prev     <= 1'b0;
      csb_prev     <= 1'b1;
      csb_prev_vld <= 1'b0;
      active       <= 1'b0;
    end else begin
      sck_prev     <= sck_s;
      csb_prev     <= csb_s;
      csb_prev_vld <= csb_s_vld;
      active       <= ~csb_s;
    end
  end

  assign sck_rise = sck_s & ~sck_prev;
  assign csb_fall = csb_prev_vld & csb_s_vld & csb_prev & ~csb_s;

  // A CSb rise wins over a simultaneous SCK rise, so no shift happens on the closing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      first_pend <= 1'b1;
      abort      <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_cnt    <= 3'd0;
          first_pend <= 1'b1;
          if (csb_fall) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (csb_s) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            abort   <= (bit_cnt != 3'd0);
          end else if (sck_rise) begin
            shreg   <= {shreg[6:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              first_pend <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign push      = (state == ST_SHIFT) & ~csb_s & sck_rise & (bit_cnt == 3'd7);
  assign push_data = {first_pend, shreg[6:0], mosi_s};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = m_valid & m_ready;
  // A pop from a full FIFO frees the slot being written in the same cycle.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign head    = mem[rd_ptr[AW-1:0]];
  assign m_valid = ~empty;
  assign m_data  = m_valid ? head[7:0] : 8'h00;
  assign m_first = m_valid ? head[8] : 1'b0;

endmodule

// File: tb/tb_spi_rx_byte_fifo.sv
// Bench for spi_rx_byte_fifo: drives SPI frames at SCK = clk/4 and compares the received
// stream against a queue-based model of tagged bytes, FIFO capacity and abort/overflow rules.
`timescale 1ns/1ps
module tb_spi_rx_byte_fifo;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_csb = 1'b1;
  logic [7:0] m_data;
  logic       m_first;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       overflow;
  logic       abort;
  logic       active;

  int n_checks = 0;
  int n_fail   = 0;
  int abort_cnt = 0;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];

  spi_rx_byte_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_csb(spi_csb),
    .m_data(m_data), .m_first(m_first), .m_valid(m_valid), .m_ready(m_ready),
    .overflow(overflow), .abort(abort), .active(active)
  );

  initial forever #5 clk = ~clk;

  // Stream monitor: records every accepted beat and every cycle abort is high.
  always @(negedge clk) begin
    #2;
    if (m_valid === 1'b1 && m_ready === 1'b1) rx_q.push_back({m_first, m_data});
    if (abort === 1'b1) abort_cnt++;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(logic b, bit pulse_ready);
    spi_mosi = b;
    tick(2);
    spi_sck = 1'b1;
    if (pulse_ready) begin
      tick(SYNC);
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
    end else begin
      tick(2);
    end
    spi_sck = 1'b0;
  endtask

  task automatic send_bits(logic [7:0] b, int nbits, bit pulse_last);
    for (int i = 0; i < nbits; i++) spi_bit(b[7-i], pulse_last && (i == nbits - 1));
  endtask

  task automatic frame_start();
    spi_csb = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    tick(4);
    spi_csb = 1'b1;
    tick(8);
  endtask

  // Model: a frame of bytes becomes tagged entries, the first carrying first=1.
  task automatic model_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, bytes[i]});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(SYNC + 2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got %h want 00", m_data); end
    n_checks++; if (m_first !== 1'b0) begin n_fail++; $display("FAIL reset_m_first got %b want 0", m_first); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort got %b want 0", abort); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", active); end
    rst = 1'b0;
    tick(SYNC + 2);
  endtask

  task automatic test_frames(string name, input logic [7:0] bytes[$]);
    rx_q.delete(); exp_q.delete(); abort_cnt = 0;
    m_ready = 1'b1;
    model_frame(bytes);
    frame_start();
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL %s_active got %b want 1", name, active); end
    foreach (bytes[i]) send_bits(bytes[i], 8, 1'b0);
    frame_end();
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL %s_inactive got %b want 0", name, active); end
    n_checks++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL %s_count got %0d want %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s_beat%0d got %h want %h", name, i, rx_q[i], exp_q[i]);
      end
    end
    n_checks++; if (abort_cnt != 0) begin n_fail++; $display("FAIL %s_abort got %0d want 0", name, abort_cnt); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL %s_overflow got %b want 0", name, overflow); end
  endtask

  task automatic test_abort();
    logic [7:0] b;
    rx_q.delete(); abort_cnt = 0; m_ready = 1'b1;
    b = 8'($urandom);
    frame_start();
    send_bits(b, 5, 1'b0);
    frame_end();
    n_checks++; if (abort_cnt != 1) begin n_fail++; $display("FAIL abort_cycles got %0d want 1", abort_cnt); end
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL abort_no_beat got %0d want 0", rx_q.size()); end
    frame_start();
    send_bits(8'h12, 8, 1'b0);
    frame_end();
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 9'h112) begin
      n_fail++; $display("FAIL abort_next got n=%0d %h want n=1 112", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
    end
    n_checks++; if (abort_cnt != 1) begin n_fail++; $display("FAIL abort_after got %0d want 1", abort_cnt); end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes[$];
    rx_q.delete(); exp_q.delete(); m_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) bytes.push_back(8'($urandom));
    model_frame(bytes);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    frame_start();
    for (int i = 0; i < DEPTH; i++) send_bits(bytes[i], 8, 1'b0);
    tick(6);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full got %b want 0", overflow); end
    n_checks++;
    if (m_valid !== 1'b1 || {m_first, m_data} !== exp_q[0]) begin
      n_fail++; $display("FAIL ovf_head_hold got v=%b %h want v=1 %h", m_valid, {m_first, m_data}, exp_q[0]);
    end
    send_bits(bytes[DEPTH], 8, 1'b0);
    tick(6);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
    frame_end();
    m_ready = 1'b1;
    tick(DEPTH + 8);
    m_ready = 1'b0;
    n_checks++;
    if (rx_q.size() != DEPTH) begin n_fail++; $display("FAIL ovf_drain_count got %0d want %0d", rx_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    pulse_reset();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got %b want 0", overflow); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] bytes[$];
    rx_q.delete(); exp_q.delete(); m_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) bytes.push_back(8'($urandom));
    model_frame(bytes);
    frame_start();
    for (int i = 0; i < DEPTH; i++) send_bits(bytes[i], 8, 1'b0);
    send_bits(bytes[DEPTH], 8, 1'b1);
    frame_end();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pushpop_overflow got %b want 0", overflow); end
    m_ready = 1'b1;
    tick(DEPTH + 8);
    m_ready = 1'b0;
    n_checks++;
    if (rx_q.size() != DEPTH + 1) begin n_fail++; $display("FAIL pushpop_count got %0d want %0d", rx_q.size(), DEPTH + 1); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pushpop_beat%0d got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    rx_q.delete(); abort_cnt = 0; m_ready = 1'b1;
    b = 8'($urandom);
    frame_start();
    send_bits(8'hF0, 4, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_m_valid got %b want 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL mid_m_data got %h want 00", m_data); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL mid_active got %b want 0", active); end
    n_checks++; if (overflow !== 1'b0 || abort !== 1'b0) begin n_fail++; $display("FAIL mid_flags got %b%b want 00", overflow, abort); end
    send_bits(8'h0F, 4, 1'b0);
    send_bits(8'($urandom), 8, 1'b0);
    tick(6);
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL mid_no_resume got %0d want 0", rx_q.size()); end
    n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL mid_active_low got %b want 1", active); end
    frame_end();
    n_checks++; if (abort_cnt != 0) begin n_fail++; $display("FAIL mid_abort got %0d want 0", abort_cnt); end
    frame_start();
    send_bits(b, 8, 1'b0);
    frame_end();
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== {1'b1, b}) begin
      n_fail++; $display("FAIL mid_resume got n=%0d %h want n=1 %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0, {1'b1, b});
    end
  endtask

  initial begin
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];
    test_reset();
    q1.push_back(8'hA5);
    test_frames("single", q1);
    q2.push_back(8'h3C); q2.push_back(8'h81); q2.push_back(8'hFF);
    test_frames("multi", q2);
    for (int i = 0; i < 5; i++) q3.push_back(8'($urandom));
    test_frames("random", q3);
    test_abort();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
